// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480 timing constants, receiver FSM states, saturating counter helper
package vga_timing_pkg;

  localparam int VGA_H_TOTAL   = 800;
  localparam int VGA_H_SYNC_BP = 144;
  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_V_TOTAL   = 525;
  localparam int VGA_V_SYNC_BP = 35;
  localparam int VGA_V_ACTIVE  = 480;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    WAIT_V = 2'd1,
    CHECK  = 2'd2,
    LOCK   = 2'd3
  } rx_state_e;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// rtl/vga_edge_detect.sv - samples one active-low sync line on the pixel tick, flags its falling edge
module vga_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic sync_i,
  output logic fall_o
);

  logic sync_q;

  // Resets low so a sync already low when reset releases is not seen as an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 1'b0;
    end else if (tick_i) begin
      sync_q <= sync_i;
    end
  end

  assign fall_o = tick_i & sync_q & ~sync_i;

endmodule

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA timing recovery, lock FSM and coordinate output
// VGA_RX_CHECKSUM_EN: adds the per-frame XOR-colour checksum on frame_sum.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL   = VGA_H_TOTAL,
  parameter int H_SYNC_BP = VGA_H_SYNC_BP,
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int V_TOTAL   = VGA_V_TOTAL,
  parameter int V_SYNC_BP = VGA_V_SYNC_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pix_valid,
  output logic        locked,
  output logic        frame_done,
  output logic        line_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_sum
);

  logic       hfall, vfall;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0] x_q, y_q;
  logic       pix_valid_q, locked_q, frame_done_q, frame_done_d, line_err_q;
  logic [7:0] err_count_q;
  logic       err, lock_next, active, pix_sample;
  rx_state_e  state_q;

  vga_edge_detect u_hs_edge (
    .clk_i(clk_50MHz), .rst_ni(reset), .tick_i(p_tick), .sync_i(hsync), .fall_o(hfall)
  );
  vga_edge_detect u_vs_edge (
    .clk_i(clk_50MHz), .rst_ni(reset), .tick_i(p_tick), .sync_i(vsync), .fall_o(vfall)
  );

  // Coordinates of a sample are the post-update counts, so the fall tick itself is hcnt 0.
  assign hcnt_d = hfall ? 10'd0 : sat_inc10(hcnt_q);
  assign vcnt_d = vfall ? 10'd0 : (hfall ? sat_inc10(vcnt_q) : vcnt_q);

  assign err = ((state_q == CHECK) || (state_q == LOCK)) &&
               ((hfall && (hcnt_q != 10'(H_TOTAL - 1))) ||
                (vfall && (vcnt_q != 10'(V_TOTAL - 1))));
  assign lock_next = !err && ((state_q == LOCK) || ((state_q == CHECK) && vfall));
  assign active = (hcnt_d >= 10'(H_SYNC_BP)) && (hcnt_d < 10'(H_SYNC_BP + H_ACTIVE)) &&
                  (vcnt_d >= 10'(V_SYNC_BP)) && (vcnt_d < 10'(V_SYNC_BP + V_ACTIVE));
  assign pix_sample = p_tick && lock_next && active;
  assign frame_done_d = pix_valid_q && (x_q == 10'(H_ACTIVE - 1)) && (y_q == 10'(V_ACTIVE - 1));

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      locked_q    <= 1'b0;
      line_err_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      line_err_q <= err;
      if (err) begin
        state_q  <= SEARCH;
        locked_q <= 1'b0;
        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end else if (p_tick) begin
        case (state_q)
          SEARCH:  if (hfall) state_q <= WAIT_V;
          WAIT_V:  if (vfall) state_q <= CHECK;
          CHECK:   if (vfall) begin
                     state_q  <= LOCK;
                     locked_q <= 1'b1;
                   end
          LOCK:    state_q <= LOCK;
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      hcnt_q       <= 10'd0;
      vcnt_q       <= 10'd0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (p_tick) begin
        hcnt_q <= hcnt_d;
        vcnt_q <= vcnt_d;
      end
      pix_valid_q  <= pix_sample;
      frame_done_q <= frame_done_d;
      if (pix_sample) begin
        x_q <= hcnt_d - 10'(H_SYNC_BP);
        y_q <= vcnt_d - 10'(V_SYNC_BP);
      end
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc_q, frame_sum_q;

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      acc_q       <= 16'h0000;
      frame_sum_q <= 16'h0000;
    end else begin
      if (frame_done_d) frame_sum_q <= acc_q;
      if (vfall || frame_done_d) begin
        acc_q <= 16'h0000;
      end else if (pix_sample) begin
        acc_q <= acc_q + {8'h00, red ^ green ^ blue};
      end
    end
  end

  assign frame_sum = frame_sum_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^{red, green, blue};
  assign frame_sum  = 16'h0000;
`endif

  assign x          = x_q;
  assign y          = y_q;
  assign pix_valid  = pix_valid_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - randomized stream bench with event-level reference model for vga_sync_receiver
module tb_vga_sync_receiver;

  localparam int HT  = 40;
  localparam int HB  = 8;
  localparam int HA  = 24;
  localparam int VT  = 20;
  localparam int VB  = 4;
  localparam int VA  = 12;
  localparam int HSW = 4;
  localparam int VSW = 2;
`ifdef VGA_RX_CHECKSUM_EN
  localparam logic [15:0] CONST_SUM = 16'h0120;
`else
  localparam logic [15:0] CONST_SUM = 16'h0000;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, p_tick = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [7:0]  red = 8'd0, green = 8'd0, blue = 8'd0;
  logic [9:0]  x, y;
  logic        pix_valid, locked, frame_done, line_err;
  logic [7:0]  err_count;
  logic [15:0] frame_sum;

  int errors = 0, checks = 0, fd_cnt = 0;
  int gap_max = 0;
  bit rand_col = 1'b0, pin_lock = 1'b0, pin_px = 1'b0, pin_err = 1'b0;
  logic       s_pv, s_locked, s_lerr;
  logic [9:0] s_x, s_y;
  logic [7:0] s_ec;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_SYNC_BP(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC_BP(VB), .V_ACTIVE(VA)
  ) dut (
    .clk_50MHz(clk), .reset(rst_n), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .x(x), .y(y), .pix_valid(pix_valid),
    .locked(locked), .frame_done(frame_done), .line_err(line_err),
    .err_count(err_count), .frame_sum(frame_sum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: ticks since last hsync fall, lines since last vsync fall,
  // and lock progress as "hsync seen" plus a count of clean vsync falls (2 = locked).
  bit m_ph, m_pvs, m_seen, m_pv, m_lerr, m_fd, m_locked, hf, vf, err;
  int m_hc, m_vc, m_nv, m_ec, m_x, m_y;
  logic [15:0] exp_sum;
`ifdef VGA_RX_CHECKSUM_EN
  int m_acc, m_sum;
`endif

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = 0; m_pvs = 0; m_seen = 0; m_pv = 0; m_lerr = 0; m_fd = 0; m_locked = 0;
      m_hc = 0; m_vc = 0; m_nv = 0; m_ec = 0; m_x = 0; m_y = 0;
`ifdef VGA_RX_CHECKSUM_EN
      m_acc = 0; m_sum = 0;
`endif
    end else begin
      m_fd = m_pv && (m_x == HA - 1) && (m_y == VA - 1);
`ifdef VGA_RX_CHECKSUM_EN
      if (m_fd) begin m_sum = m_acc; m_acc = 0; end
`endif
      m_pv = 0;
      m_lerr = 0;
      if (p_tick) begin
        hf = m_ph && !hsync;
        vf = m_pvs && !vsync;
        m_ph = hsync;
        m_pvs = vsync;
        err = m_seen && (m_nv >= 1) && ((hf && m_hc != HT - 1) || (vf && m_vc != VT - 1));
        m_hc = hf ? 0 : ((m_hc < 1023) ? m_hc + 1 : 1023);
        m_vc = vf ? 0 : (hf ? ((m_vc < 1023) ? m_vc + 1 : 1023) : m_vc);
        if (!m_seen) m_seen = hf;
        else if (err) begin
          m_seen = 0; m_nv = 0;
          if (m_ec < 255) m_ec++;
        end else if (vf && m_nv < 2) m_nv++;
        m_lerr = err;
        m_locked = (m_nv == 2);
        if (m_locked && m_hc >= HB && m_hc < HB + HA && m_vc >= VB && m_vc < VB + VA) begin
          m_pv = 1;
          m_x = m_hc - HB;
          m_y = m_vc - VB;
`ifdef VGA_RX_CHECKSUM_EN
          if (!m_fd) m_acc = (m_acc + int'(red ^ green ^ blue)) % 65536;
`endif
        end
`ifdef VGA_RX_CHECKSUM_EN
        if (vf) m_acc = 0;
`endif
      end
    end
`ifdef VGA_RX_CHECKSUM_EN
    exp_sum = 16'(m_sum);
`else
    exp_sum = 16'h0000;
`endif
    #1;
    checks++;
    if ({x, y, pix_valid, locked, frame_done, line_err, err_count, frame_sum} !==
        {10'(m_x), 10'(m_y), m_pv, m_locked, m_fd, m_lerr, 8'(m_ec), exp_sum}) begin
      errors++;
      $display("FAIL cycle_model t=%0t got x=%0d y=%0d pv=%0b lk=%0b fd=%0b le=%0b ec=%0d sum=%0h expected x=%0d y=%0d pv=%0b lk=%0b fd=%0b le=%0b ec=%0d sum=%0h",
               $time, x, y, pix_valid, locked, frame_done, line_err, err_count, frame_sum,
               m_x, m_y, m_pv, m_locked, m_fd, m_lerr, m_ec, exp_sum);
    end
  end

  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic tick(input logic hs, input logic vs);
    @(negedge clk);
    hsync = hs;
    vsync = vs;
    p_tick = 1'b1;
    if (rand_col) {red, green, blue} = 24'($urandom);
    else begin red = 8'h01; green = 8'h00; blue = 8'h00; end
    @(negedge clk);
    p_tick = 1'b0;
    s_pv = pix_valid; s_x = x; s_y = y; s_locked = locked; s_lerr = line_err; s_ec = err_count;
    repeat ((gap_max > 0) ? $urandom_range(0, gap_max) : 0) @(negedge clk);
  endtask

  task automatic send_line(input int v, input int len);
    for (int h = 0; h < len; h++) begin
      if (pin_lock && v == 0 && h == 0) check("locked_before_rise", 32'(s_locked), 0);
      tick(h >= HSW, v >= VSW);
      if (pin_lock && v == 0 && h == 0) begin
        check("locked_rise", 32'(s_locked), 1);
        pin_lock = 1'b0;
      end
      if (pin_err && h == 0) begin
        check("line_err_pulse", 32'(s_lerr), 1);
        check("err_count_one", 32'(s_ec), 1);
        check("locked_drop", 32'(s_locked), 0);
        pin_err = 1'b0;
      end
      if (pin_px && v == VB && h == HB) begin
        check("first_pv", 32'(s_pv), 1);
        check("first_x", 32'(s_x), 0);
        check("first_y", 32'(s_y), 0);
      end
      if (pin_px && v == VB + VA - 1 && h == HB + HA - 1) begin
        check("last_pv", 32'(s_pv), 1);
        check("last_x", 32'(s_x), HA - 1);
        check("last_y", 32'(s_y), VA - 1);
        pin_px = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input int v0, input int v1);
    for (int v = v0; v < v1; v++) send_line(v, HT);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_pv"}, 32'(pix_valid), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_fd"}, 32'(frame_done), 0);
    check({tag, "_lerr"}, 32'(line_err), 0);
    check({tag, "_ec"}, 32'(err_count), 0);
    check({tag, "_sum"}, 32'(frame_sum), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    send_line(VT - 1, HT);
    send_frame(0, VT);
    pin_lock = 1'b1; pin_px = 1'b1;
    send_frame(0, VT);
    check("frame_done_after_f1", 32'(fd_cnt), 1);
    check("frame_sum_const", 32'(frame_sum), 32'(CONST_SUM));
    send_frame(0, VT);
    check("frame_done_after_f2", 32'(fd_cnt), 2);

    rand_col = 1'b1; gap_max = 1;
    send_frame(0, VT);
    send_frame(0, 8);
    send_line(8, HT - 1);
    pin_err = 1'b1;
    send_frame(9, VT);
    send_frame(0, VT);
    pin_lock = 1'b1;
    send_frame(0, VT);
    send_frame(0, VT);
    send_frame(0, VT - 1);
    send_frame(0, VT);
    check("err_count_vmismatch", 32'(err_count), 2);
    send_frame(0, VT);
    pin_lock = 1'b1;
    send_frame(0, 10);
    check("locked_before_reset", 32'(locked), 1);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_frame(10, VT);
    send_frame(0, VT);
    pin_lock = 1'b1;
    send_frame(0, VT);

    gap_max = 0;
    for (int i = 0; i < 300; i++) begin
      for (int l = 0; l < 3; l++)
        for (int h = 0; h < 5; h++) tick(h >= 2, l != 1);
    end
    check("err_count_saturated", 32'(err_count), 255);
    check("locked_after_storm", 32'(locked), 0);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
